// File: rtl/rst_cipher_ctrl.sv
// Sequencing controller for the RST cipher core: key install, plaintext
// streaming, and an output FIFO that buffers ciphertext pairs.
module rst_cipher_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int KEY_WAIT   = 2,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [95:0]      key_in,
    input  logic             key_load,
    input  logic [7:0]       s_char,
    input  logic             s_valid,
    input  logic             s_last,
    output logic             s_ready,
    output logic [15:0]      m_ctxt,
    output logic             m_err,
    output logic             m_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             core_rst_n,
    output logic [95:0]      core_key,
    output logic [7:0]       core_ptxt_char,
    output logic             core_ptxt_valid,
    input  logic [15:0]      core_ctxt,
    input  logic             core_ctxt_ready,
    input  logic             core_err_invalid_ptxt,
    input  logic             core_err_invalid_key,
    output logic             key_ok,
    output logic             key_err,
    output logic             busy,
    output logic [CNT_W-1:0] char_cnt,
    output logic [CNT_W-1:0] err_cnt
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int WW = (KEY_WAIT > 1) ? $clog2(KEY_WAIT) : 1;
    localparam logic [WW-1:0] WAIT_LAST = WW'(KEY_WAIT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_KEY_RST, S_KEY_WAIT, S_READY, S_STREAM, S_KEY_ERR
    } state_t;

    state_t        state;
    logic [WW-1:0] wait_cnt;
    logic          key_pend;
    logic [95:0]   pend_key;
    logic          ptxt_last;
    logic          resp_exp;
    logic          resp_last;

    logic [17:0]   fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   fifo_count;
    logic [17:0]   head;

    logic          stream_st;
    logic          inflight_any;
    logic [PW+1:0] occ;
    logic          accept;
    logic          push;
    logic          pop;
    logic          full;

    // Handshake, occupancy and FIFO head decode.
    // In-flight chars are exactly the two pipeline stages: issued (core_ptxt_valid)
    // and awaiting the core response (resp_exp), so no separate counter is kept.
    always_comb begin
        stream_st    = (state == S_READY) || (state == S_STREAM);
        inflight_any = core_ptxt_valid | resp_exp;
        occ          = (PW+2)'(fifo_count) + (PW+2)'(core_ptxt_valid) + (PW+2)'(resp_exp);
        s_ready      = stream_st && !key_load && !key_pend && (occ < (PW+2)'(FIFO_DEPTH));
        accept       = s_valid & s_ready;
        push         = resp_exp & (core_ctxt_ready | core_err_invalid_ptxt);
        m_valid      = (fifo_count != '0);
        pop          = m_valid & m_ready;
        full         = (fifo_count == (PW+1)'(FIFO_DEPTH));
        head         = fifo_mem[rd_ptr];
        m_ctxt       = m_valid ? head[15:0] : '0;
        m_last       = m_valid & head[16];
        m_err        = m_valid & head[17];
        busy         = (state == S_KEY_RST) || (state == S_KEY_WAIT) || inflight_any;
    end

    // Control FSM, issue pipeline and status counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= S_IDLE;
            wait_cnt        <= '0;
            key_pend        <= 1'b0;
            pend_key        <= '0;
            core_rst_n      <= 1'b0;
            core_key        <= '0;
            core_ptxt_char  <= '0;
            core_ptxt_valid <= 1'b0;
            ptxt_last       <= 1'b0;
            resp_exp        <= 1'b0;
            resp_last       <= 1'b0;
            key_ok          <= 1'b0;
            key_err         <= 1'b0;
            char_cnt        <= '0;
            err_cnt         <= '0;
        end else begin
            core_ptxt_valid <= accept;
            if (accept) begin
                core_ptxt_char <= s_char;
                ptxt_last      <= s_last;
            end
            resp_exp  <= core_ptxt_valid;
            resp_last <= ptxt_last;
            if (accept && (char_cnt != '1))
                char_cnt <= char_cnt + 1'b1;
            if (push && core_err_invalid_ptxt && (err_cnt != '1))
                err_cnt <= err_cnt + 1'b1;

            case (state)
                S_IDLE, S_KEY_ERR: begin
                    if (key_load) begin
                        core_key   <= key_in;
                        core_rst_n <= 1'b0;
                        key_ok     <= 1'b0;
                        key_err    <= 1'b0;
                        state      <= S_KEY_RST;
                    end
                end
                S_KEY_RST: begin
                    core_rst_n <= 1'b1;
                    wait_cnt   <= '0;
                    key_pend   <= 1'b0;
                    char_cnt   <= '0;
                    err_cnt    <= '0;
                    state      <= S_KEY_WAIT;
                end
                S_KEY_WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        key_err <= core_err_invalid_key;
                        key_ok  <= !core_err_invalid_key;
                        state   <= core_err_invalid_key ? S_KEY_ERR : S_READY;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_READY, S_STREAM: begin
                    if (key_load || key_pend) begin
                        // A reload waits for the pipeline to drain so no issued
                        // rotation is lost mid-flight; the newest key wins.
                        if (!inflight_any) begin
                            core_key   <= key_load ? key_in : pend_key;
                            core_rst_n <= 1'b0;
                            key_ok     <= 1'b0;
                            key_err    <= 1'b0;
                            key_pend   <= 1'b0;
                            state      <= S_KEY_RST;
                        end else begin
                            key_pend <= 1'b1;
                            if (key_load)
                                pend_key <= key_in;
                        end
                    end else if (accept) begin
                        state <= S_STREAM;
                    end else if (push && resp_last && !core_ptxt_valid) begin
                        state <= S_READY;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // FIFO pointers and occupancy; flushed while the core is held in reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else if (state == S_KEY_RST) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            fifo_count <= fifo_count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    // FIFO storage: error entries carry a zero ciphertext.
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= {core_err_invalid_ptxt, resp_last,
                                 core_err_invalid_ptxt ? 16'h0000 : core_ctxt};
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));

endmodule

// File: tb/tb_rst_cipher_ctrl.sv
// Scoreboard bench for rst_cipher_ctrl with a behavioural cipher core stand-in.
module tb_rst_cipher_ctrl;
    localparam int FD = 4;
    localparam int KW = 2;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [95:0]   key_in = '0;
    logic          key_load = 1'b0;
    logic [7:0]    s_char = '0;
    logic          s_valid = 1'b0;
    logic          s_last = 1'b0;
    logic          s_ready;
    logic [15:0]   m_ctxt;
    logic          m_err, m_last, m_valid;
    logic          m_ready = 1'b0;
    logic          core_rst_n;
    logic [95:0]   core_key;
    logic [7:0]    core_ptxt_char;
    logic          core_ptxt_valid;
    logic [15:0]   core_ctxt;
    logic          core_ctxt_ready;
    logic          core_err_invalid_ptxt;
    logic          core_err_invalid_key;
    logic          key_ok, key_err, busy;
    logic [CW-1:0] char_cnt, err_cnt;

    logic          spur = 1'b0;
    logic          force_both = 1'b0;
    logic          key_bad;

    int            compared = 0;
    int            mismatched = 0;
    logic [17:0]   exp_q [$];
    int            cyc = 0;
    int            issue_cyc [$];

    rst_cipher_ctrl #(.FIFO_DEPTH(FD), .KEY_WAIT(KW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .key_in(key_in), .key_load(key_load),
        .s_char(s_char), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .m_ctxt(m_ctxt), .m_err(m_err), .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready),
        .core_rst_n(core_rst_n), .core_key(core_key), .core_ptxt_char(core_ptxt_char),
        .core_ptxt_valid(core_ptxt_valid), .core_ctxt(core_ctxt), .core_ctxt_ready(core_ctxt_ready),
        .core_err_invalid_ptxt(core_err_invalid_ptxt), .core_err_invalid_key(core_err_invalid_key),
        .key_ok(key_ok), .key_err(key_err), .busy(busy), .char_cnt(char_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic char_bad(input logic [7:0] c);
        return (c < 8'h61) || (c > 8'h7a);
    endfunction

    // Core stand-in: a key containing '?' is rejected; ciphertext = {char, char+1}.
    always_comb begin
        key_bad = 1'b0;
        for (int i = 0; i < 12; i++)
            if (core_key[i*8 +: 8] == 8'h3F) key_bad = 1'b1;
    end
    assign core_err_invalid_key = core_rst_n & key_bad;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            core_ctxt             <= '0;
            core_ctxt_ready       <= 1'b0;
            core_err_invalid_ptxt <= 1'b0;
        end else begin
            core_ctxt             <= {core_ptxt_char, core_ptxt_char + 8'd1};
            core_ctxt_ready       <= (core_ptxt_valid && !char_bad(core_ptxt_char)) || spur;
            core_err_invalid_ptxt <= core_ptxt_valid && (char_bad(core_ptxt_char) || force_both);
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (core_ptxt_valid) issue_cyc.push_back(cyc);

    // Monitor: pops the scoreboard whenever the DUT hands over an entry.
    always @(negedge clk) begin
        logic [17:0] act, req;
        if (!rst && m_valid && m_ready) begin
            act = {m_err, m_last, m_ctxt};
            compared++;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_entry: got %h, required no entry", act);
            end else begin
                req = exp_q.pop_front();
                if (act !== req) begin
                    mismatched++;
                    $display("FAIL entry {err,last,ctxt}: got %h, required %h", act, req);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one char; the expectation is queued on the accepting edge.
    task automatic send1(input logic [7:0] c, input logic l, input logic [15:0] ectxt, input logic eerr);
        int budget;
        budget = 60;
        s_char  = c;
        s_last  = l;
        s_valid = 1'b1;
        while (!s_ready && budget > 0) begin
            tick();
            budget--;
        end
        if (!s_ready) begin
            chk("accept_timeout", 96'(s_ready), 96'(1));
        end else begin
            exp_q.push_back({eerr, l, ectxt});
            tick();
        end
        s_valid = 1'b0;
    endtask

    task automatic drain();
        int budget;
        budget = 100;
        while ((exp_q.size() != 0 || m_valid) && budget > 0) begin
            tick();
            budget--;
        end
        chk("drain_pending", 96'(exp_q.size()), 96'(0));
        chk("drain_m_valid", 96'(m_valid), 96'(0));
    endtask

    // Install with exact timing: core reset low 1 cycle, result after 1+KEY_WAIT edges.
    task automatic install(input logic [95:0] k, input logic ok);
        key_in   = k;
        key_load = 1'b1;
        #1;
        chk("s_ready_during_load", 96'(s_ready), 96'(0));
        tick();
        key_load = 1'b0;
        chk("key_rst_core_rst_n", 96'(core_rst_n), 96'(0));
        chk("key_rst_core_key", core_key, k);
        chk("key_rst_busy", 96'(busy), 96'(1));
        tick();
        chk("key_wait_core_rst_n", 96'(core_rst_n), 96'(1));
        repeat (KW - 1) tick();
        chk("key_wait_key_ok", 96'(key_ok), 96'(0));
        tick();
        chk("install_key_ok", 96'(key_ok), 96'(ok));
        chk("install_key_err", 96'(key_err), 96'(!ok));
        chk("install_s_ready", 96'(s_ready), 96'(ok));
        chk("install_busy", 96'(busy), 96'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) tick();
        chk("rst_core_rst_n", 96'(core_rst_n), 96'(0));
        chk("rst_s_ready", 96'(s_ready), 96'(0));
        chk("rst_key_ok", 96'(key_ok), 96'(0));
        chk("rst_m_valid", 96'(m_valid), 96'(0));
        chk("rst_core_key", core_key, 96'(0));
        chk("rst_char_cnt", 96'(char_cnt), 96'(0));
        rst = 1'b0;
        tick();
        chk("idle_s_ready", 96'(s_ready), 96'(0));

        // Good key, then bad key, then good key again
        install("abcdefghijkl", 1'b1);
        install("abcdefghi?kl", 1'b0);
        repeat (3) tick();
        chk("key_err_hold_s_ready", 96'(s_ready), 96'(0));
        chk("key_err_hold", 96'(key_err), 96'(1));
        install("abcdefghijkl", 1'b1);

        // "ab" back to back
        m_ready = 1'b1;
        issue_cyc.delete();
        send1("a", 1'b0, 16'h6162, 1'b0);
        send1("b", 1'b1, 16'h6263, 1'b0);
        drain();
        chk("ab_issue_count", 96'(issue_cyc.size()), 96'(2));
        chk("ab_issue_gap", 96'((issue_cyc.size() >= 2) ? (issue_cyc[1] - issue_cyc[0]) : 0), 96'(1));
        chk("ab_char_cnt", 96'(char_cnt), 96'(2));
        chk("ab_err_cnt", 96'(err_cnt), 96'(0));

        // "a?b" with an invalid middle char
        send1("a", 1'b0, 16'h6162, 1'b0);
        send1("?", 1'b0, 16'h0000, 1'b1);
        send1("b", 1'b1, 16'h6263, 1'b0);
        drain();
        chk("a?b_char_cnt", 96'(char_cnt), 96'(5));
        chk("a?b_err_cnt", 96'(err_cnt), 96'(1));

        // Back-pressure: only FIFO_DEPTH chars may be outstanding
        m_ready = 1'b0;
        fork
            begin
                send1("c", 1'b0, 16'h6364, 1'b0);
                send1("d", 1'b0, 16'h6465, 1'b0);
                send1("e", 1'b0, 16'h6566, 1'b0);
                send1("f", 1'b0, 16'h6667, 1'b0);
                send1("g", 1'b0, 16'h6768, 1'b0);
                send1("h", 1'b1, 16'h6869, 1'b0);
            end
        join_none
        repeat (10) tick();
        chk("bp_char_cnt", 96'(char_cnt), 96'(9));
        chk("bp_s_ready", 96'(s_ready), 96'(0));
        chk("bp_m_valid", 96'(m_valid), 96'(1));
        m_ready = 1'b1;
        wait fork;
        drain();
        chk("bp_char_cnt_final", 96'(char_cnt), 96'(11));

        // Response with no issue is ignored
        spur = 1'b1;
        tick();
        spur = 1'b0;
        repeat (3) tick();
        chk("spur_m_valid", 96'(m_valid), 96'(0));
        chk("spur_char_cnt", 96'(char_cnt), 96'(11));
        chk("spur_err_cnt", 96'(err_cnt), 96'(1));

        // Both strobes at once -> error entry
        force_both = 1'b1;
        send1("x", 1'b1, 16'h0000, 1'b1);
        drain();
        force_both = 1'b0;
        chk("both_err_cnt", 96'(err_cnt), 96'(2));

        // Deferred reload while chars are in flight; FIFO flushed
        m_ready = 1'b0;
        send1("p", 1'b0, 16'h7071, 1'b0);
        send1("q", 1'b1, 16'h7172, 1'b0);
        key_in   = "mnopqrstuvwx";
        key_load = 1'b1;
        #1;
        chk("defer_s_ready", 96'(s_ready), 96'(0));
        tick();
        key_load = 1'b0;
        chk("defer_core_rst_n_k0", 96'(core_rst_n), 96'(1));
        chk("defer_busy", 96'(busy), 96'(1));
        tick();
        chk("defer_core_rst_n_k1", 96'(core_rst_n), 96'(1));
        chk("defer_core_key_old", core_key, 96'("abcdefghijkl"));
        tick();
        chk("defer_core_rst_n_k2", 96'(core_rst_n), 96'(0));
        chk("defer_core_key_new", core_key, 96'("mnopqrstuvwx"));
        exp_q.delete();
        tick();
        chk("defer_flushed", 96'(m_valid), 96'(0));
        chk("defer_char_cnt", 96'(char_cnt), 96'(0));
        chk("defer_err_cnt", 96'(err_cnt), 96'(0));
        repeat (KW) tick();
        chk("defer_key_ok", 96'(key_ok), 96'(1));

        // Async reset mid-stream
        s_char  = "b";
        s_last  = 1'b0;
        s_valid = 1'b1;
        tick();
        tick();
        #3;
        rst = 1'b1;
        #1;
        chk("arst_core_rst_n", 96'(core_rst_n), 96'(0));
        chk("arst_key_ok", 96'(key_ok), 96'(0));
        chk("arst_m_valid", 96'(m_valid), 96'(0));
        chk("arst_s_ready", 96'(s_ready), 96'(0));
        chk("arst_core_ptxt_valid", 96'(core_ptxt_valid), 96'(0));
        chk("arst_char_cnt", 96'(char_cnt), 96'(0));
        chk("arst_core_key", core_key, 96'(0));
        chk("arst_busy", 96'(busy), 96'(0));
        s_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        chk("post_arst_m_valid", 96'(m_valid), 96'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
